rx_unit: RTL and testbench

RX_UNIT -- requirements
Module: rx_unit

---
 rtl/rx_unit_pkg.sv | 34 +++
 rtl/rx_unit_ctrl.sv | 112 +++++++++++
 rtl/rx_unit.sv | 87 ++++++++
 tb/tb_rx_unit.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_unit_pkg.sv
// rx_unit_pkg -- UART constants and types shared by the receive and transmit sides.
//   Receive FSM state encoding, default oversample ratio, data-bit count,
//   transmit-side framing constants and an even-parity check helper.
// Build option: define UART_RX_PARITY_EN to add one even-parity bit after the
//   data bits; without it the parity state is never entered and pe stays 0.
package rx_unit_pkg;

  localparam int OSR_DEFAULT  = 16;  // en_rx ticks per bit period
  localparam int DATA_BITS    = 8;

  // Transmit-side framing constants kept next to the receive ones.
  localparam int TX_STOP_BITS = 1;
  localparam int TX_OSR       = OSR_DEFAULT;

`ifdef UART_RX_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_PAR   = 3'd3,
    RX_STOP  = 3'd4
  } rx_state_t;

  // 1 when data plus parity bit hold an odd number of ones (even parity broken).
  function automatic logic parity_err(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/rx_unit_ctrl.sv
// rx_ctrl -- receive-line synchronizer, framing FSM and oversample/bit counters.
//   clk, rst    : clock, asynchronous active-low reset
//   rxd         : raw serial line (idles high)
//   en_rx       : oversample tick; counters and FSM move only on it
//   rxd_sync    : synchronized line, the only copy of rxd used downstream
//   shift_stb   : mid data bit, shift rxd_sync into the data register
//   par_stb     : mid parity bit, capture rxd_sync as the parity bit
//   load_stb    : mid stop bit, rxd_sync is the stop bit, load the byte
//   state       : current FSM state (debug visibility)
// Build option UART_RX_PARITY_EN (via rx_unit_pkg) enables the RX_PAR state.
module rx_ctrl
  import rx_unit_pkg::*;
#(
  parameter int OSR = OSR_DEFAULT
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      rxd,
  input  logic      en_rx,
  output logic      rxd_sync,
  output logic      shift_stb,
  output logic      par_stb,
  output logic      load_stb,
  output rx_state_t state
);

  localparam int            CW        = $clog2(OSR);
  localparam logic [CW-1:0] HALF_LAST = CW'(OSR / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(OSR - 1);
  localparam logic [3:0]    LAST_BIT  = 4'(DATA_BITS - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;
  logic [3:0]    bit_cnt;
  logic          armed;   // line seen high in IDLE since the last frame
  logic          full_tick;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= rxd;
      sync2 <= sync1;
    end
  end

  assign rxd_sync  = sync2;
  assign full_tick = en_rx && (cnt == FULL_LAST);

  // Strobes are decodes of registered state so the datapath acts on the
  // same edge the FSM leaves the bit; this keeps the load mid stop bit.
  assign shift_stb = (state == RX_DATA) && full_tick;
  assign par_stb   = (state == RX_PAR)  && full_tick;
  assign load_stb  = (state == RX_STOP) && full_tick;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= RX_IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      armed   <= 1'b0;
    end else if (en_rx) begin
      case (state)
        RX_IDLE: begin
          cnt     <= '0;
          bit_cnt <= '0;
          // A break (line still low after a frame) must not restart the FSM.
          if (!sync2 && armed) state <= RX_START;
          else if (sync2)      armed <= 1'b1;
        end
        RX_START: begin
          if (cnt == HALF_LAST) begin
            cnt   <= '0;
            state <= sync2 ? RX_IDLE : RX_DATA;  // high at mid start: glitch
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == FULL_LAST) begin
            cnt     <= '0;
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == LAST_BIT) state <= PARITY_EN ? RX_PAR : RX_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_PAR: begin
          if (cnt == FULL_LAST) begin
            cnt   <= '0;
            state <= RX_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt == FULL_LAST) begin
            cnt   <= '0;
            armed <= 1'b0;
            state <= RX_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/rx_unit.sv
// rx_unit -- UART receiver: framing control (rx_ctrl), data shift register,
//   parity capture and the held byte with its status flags.
//   clk, rst : clock, asynchronous active-low reset
//   rxd      : serial line, idles high
//   en_rx    : oversample tick, OSR ticks per bit
//   rd       : read strobe
//   d_out    : last received byte
//   rs       : unread byte held
//   fe       : framing error (stop bit sampled 0)
//   oe       : overrun (byte loaded while previous one unread)
//   pe       : parity error (always 0 unless UART_RX_PARITY_EN is defined)
//   state    : receive FSM state (debug visibility)
// Build option: UART_RX_PARITY_EN adds even-parity checking.
//
// Read handshake: rs=1 means d_out/fe/oe/pe describe an unread byte. A one-clk
// rd acknowledges it and clears rs/fe/oe/pe on the next edge; d_out is held.
// If a new byte loads on the same edge as rd, the load wins (rs=1, oe=0).
module rx_unit
  import rx_unit_pkg::*;
#(
  parameter int OSR = OSR_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  input  logic       en_rx,
  input  logic       rd,
  output logic [7:0] d_out,
  output logic       rs,
  output logic       fe,
  output logic       oe,
  output logic       pe,
  output rx_state_t  state
);

  logic       rxd_sync;
  logic       shift_stb;
  logic       par_stb;
  logic       load_stb;
  logic [7:0] shreg;
  logic       par_bit;

  rx_ctrl #(.OSR(OSR)) u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .en_rx     (en_rx),
    .rxd_sync  (rxd_sync),
    .shift_stb (shift_stb),
    .par_stb   (par_stb),
    .load_stb  (load_stb),
    .state     (state)
  );

  // LSB arrives first, so bits enter at the top and walk down.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg   <= '0;
      par_bit <= 1'b0;
    end else begin
      if (shift_stb) shreg   <= {rxd_sync, shreg[7:1]};
      if (par_stb)   par_bit <= rxd_sync;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_out <= 8'h00;
      rs    <= 1'b0;
      fe    <= 1'b0;
      oe    <= 1'b0;
      pe    <= 1'b0;
    end else if (load_stb) begin
      d_out <= shreg;               // newest byte wins, even with fe
      rs    <= 1'b1;
      fe    <= ~rxd_sync;
      pe    <= PARITY_EN & parity_err(shreg, par_bit);
      oe    <= rs & ~rd;
    end else if (rd) begin
      rs <= 1'b0;
      fe <= 1'b0;
      oe <= 1'b0;
      pe <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rx_unit.sv
// tb_rx_unit -- self-checking bench for rx_unit (OSR=16, en_rx tied high).
//   Frames are driven bit by bit; a frame-level model of the held byte and
//   flags predicts d_out/rs/fe/oe/pe after each frame or read strobe.
module tb_rx_unit;
  import rx_unit_pkg::*;

  localparam int OSR = 16;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic       clk;
  logic       rst;
  logic       rxd;
  logic       en_rx;
  logic       rd;
  logic [7:0] d_out;
  logic       rs;
  logic       fe;
  logic       oe;
  logic       pe;
  rx_state_t  state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  rx_unit #(.OSR(OSR)) dut (
    .clk   (clk),
    .rst   (rst),
    .rxd   (rxd),
    .en_rx (en_rx),
    .rd    (rd),
    .d_out (d_out),
    .rs    (rs),
    .fe    (fe),
    .oe    (oe),
    .pe    (pe),
    .state (state)
  );

  // ---------------- scoreboard ----------------
  int         n_cmp;
  int         n_bad;
  logic [7:0] exp_q[$];   // bytes the model expects to have been loaded
  logic       exp_rs;
  logic       exp_fe;
  logic       exp_oe;
  logic       exp_pe;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic int ones(input logic [7:0] d);
    int n;
    n = 0;
    for (int i = 0; i < 8; i++) n += int'(d[i]);
    return n;
  endfunction

  function automatic logic good_par(input logic [7:0] d);
    return logic'(ones(d) % 2);
  endfunction

  task automatic model_reset();
    exp_q.delete();
    exp_rs = 1'b0;
    exp_fe = 1'b0;
    exp_oe = 1'b0;
    exp_pe = 1'b0;
  endtask

  // Byte received: rd on the same edge suppresses overrun, otherwise an
  // already-held byte means overrun.
  task automatic model_frame(input logic [7:0] data, input logic stop_b,
                             input logic par_b, input bit rd_hit);
    exp_oe = exp_rs && !rd_hit;
    exp_rs = 1'b1;
    exp_fe = !stop_b;
    exp_pe = PAR ? logic'((ones(data) + int'(par_b)) % 2) : 1'b0;
    exp_q.push_back(data);
  endtask

  task automatic model_read();
    exp_rs = 1'b0;
    exp_fe = 1'b0;
    exp_oe = 1'b0;
    exp_pe = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    logic [7:0] exp_d;
    exp_d = (exp_q.size() > 0) ? exp_q[exp_q.size()-1] : 8'h00;
    check({tag, "_d_out"}, 32'(d_out), 32'(exp_d));
    check({tag, "_rs"},    32'(rs),    32'(exp_rs));
    check({tag, "_fe"},    32'(fe),    32'(exp_fe));
    check({tag, "_oe"},    32'(oe),    32'(exp_oe));
    check({tag, "_pe"},    32'(pe),    32'(exp_pe));
  endtask

  // ---------------- driver tasks ----------------
  // All drives happen on the falling clock edge; outputs are read there too.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rxd = 1'b1;
      rd  = 1'b0;
    end
  endtask

  task automatic hold_low(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rxd = 1'b0;
      rd  = 1'b0;
    end
  endtask

  task automatic pulse_rd();
    @(negedge clk);
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    model_read();
  endtask

  // Drive one frame; rd is raised for the single cycle index rd_at (-1: none).
  // load_cyc is the first cycle (from the start-bit drive) at which rs is seen
  // rising, or -1.
  task automatic send_frame(input logic [7:0] data, input logic stop_b,
                            input logic par_b, input int rd_at, output int load_cyc);
    logic bits[$];
    logic prev_rs;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(data[i]);
    if (PAR) bits.push_back(par_b);
    bits.push_back(stop_b);
    load_cyc = -1;
    prev_rs  = rs;
    for (int c = 0; c < bits.size() * OSR; c++) begin
      @(negedge clk);
      if (load_cyc < 0 && rs && !prev_rs) load_cyc = c;
      prev_rs = rs;
      rxd = bits[c / OSR];
      rd  = (c == rd_at);
    end
    @(negedge clk);
    rd = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int         lat_a5;
  int         lat_ref;
  int         lo;
  int         dummy;
  logic [7:0] f0;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b0;
    rxd   = 1'b1;
    en_rx = 1'b1;
    rd    = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs("reset");
    check("reset_state", 32'(state), 32'(RX_IDLE));
    rst = 1'b1;
    idle(10);

    // Clean frame and start-to-load latency.
    send_frame(8'hA5, 1'b1, good_par(8'hA5), -1, lat_a5);
    model_frame(8'hA5, 1'b1, good_par(8'hA5), 1'b0);
    idle(8);
    check_outputs("a5");
    lo = 152 + (PAR ? OSR : 0);
    check("a5_latency_ok", 32'(lat_a5 >= lo && lat_a5 <= lo + 4), 32'd1);
    lat_ref = (lat_a5 > 0) ? lat_a5 : lo + 3;
    pulse_rd();
    check_outputs("a5_rd");

    // Overrun: two unread bytes, newest kept.
    send_frame(8'h3C, 1'b1, good_par(8'h3C), -1, dummy);
    model_frame(8'h3C, 1'b1, good_par(8'h3C), 1'b0);
    idle(6);
    check_outputs("3c");
    send_frame(8'h81, 1'b1, good_par(8'h81), -1, dummy);
    model_frame(8'h81, 1'b1, good_par(8'h81), 1'b0);
    idle(6);
    check_outputs("81_ovr");
    pulse_rd();
    check_outputs("81_rd");

    // Framing error followed by a break: no false restart while low.
    send_frame(8'h55, 1'b0, good_par(8'h55), -1, dummy);
    model_frame(8'h55, 1'b0, good_par(8'h55), 1'b0);
    hold_low(40);
    check_outputs("55_fe");
    check("brk_state", 32'(state), 32'(RX_IDLE));
    pulse_rd();
    hold_low(250);
    check_outputs("brk_hold");
    check("brk_state2", 32'(state), 32'(RX_IDLE));
    idle(10);
    send_frame(8'h12, 1'b1, good_par(8'h12), -1, dummy);
    model_frame(8'h12, 1'b1, good_par(8'h12), 1'b0);
    idle(6);
    check_outputs("12_after_brk");

    // Short low glitch is rejected.
    hold_low(4);
    idle(40);
    check_outputs("glitch");
    check("glitch_state", 32'(state), 32'(RX_IDLE));

    // rd on the load edge: load wins, no overrun.
    send_frame(8'hC3, 1'b1, good_par(8'hC3), lat_ref - 1, dummy);
    model_frame(8'hC3, 1'b1, good_par(8'hC3), 1'b1);
    idle(6);
    check_outputs("c3_rd_load");

    // Reset in the middle of bit 3 of 0xF0, then a fresh frame.
    f0 = 8'hF0;
    for (int c = 0; c < 4 * OSR + OSR / 2; c++) begin
      @(negedge clk);
      rxd = (c < OSR) ? 1'b0 : f0[c / OSR - 1];
    end
    @(negedge clk);
    rst = 1'b0;
    rxd = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs("mid_rst");
    check("mid_rst_state", 32'(state), 32'(RX_IDLE));
    rst = 1'b1;
    idle(10);
    send_frame(8'h0F, 1'b1, good_par(8'h0F), -1, dummy);
    model_frame(8'h0F, 1'b1, good_par(8'h0F), 1'b0);
    idle(6);
    check_outputs("0f_after_rst");

`ifdef UART_RX_PARITY_EN
    pulse_rd();
    send_frame(8'h07, 1'b1, 1'b0, -1, dummy);
    model_frame(8'h07, 1'b1, 1'b0, 1'b0);
    idle(6);
    check("07_par0_pe", 32'(pe), 32'd1);
    check_outputs("07_par0");
    pulse_rd();
    send_frame(8'h07, 1'b1, 1'b1, -1, dummy);
    model_frame(8'h07, 1'b1, 1'b1, 1'b0);
    idle(6);
    check("07_par1_pe", 32'(pe), 32'd0);
    check_outputs("07_par1");
`endif

    // Randomized frames: data, stop bit, parity bit, rd timing, gaps.
    for (int f = 0; f < 24; f++) begin
      logic [7:0] data;
      logic       stop_b;
      logic       par_b;
      bit         hit;
      data   = 8'($urandom);
      stop_b = ($urandom_range(0, 3) != 0);
      par_b  = ($urandom_range(0, 3) != 0) ? good_par(data) : ~good_par(data);
      hit    = ($urandom_range(0, 4) == 0);
      send_frame(data, stop_b, par_b, hit ? lat_ref - 1 : -1, dummy);
      model_frame(data, stop_b, par_b, hit);
      idle($urandom_range(4, 30));
      check_outputs("rand");
      if ($urandom_range(0, 2) == 0) begin
        pulse_rd();
        check_outputs("rand_rd");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
